// File: rtl/nco_dac_spi.sv
// nco_dac_spi: samples NCO sine/cosine on a tick and shifts them out as two 24-bit SPI DAC frames.
// Build option: define OFFSET_BINARY_EN to invert the sample MSB (two's complement -> offset binary).
module nco_dac_spi #(
    parameter int         DATA_WIDTH = 16,
    parameter int         SCLK_HALF  = 2,
    parameter int         SAMPLE_DIV = 250,
    parameter logic [3:0] CMD_WRITE  = 4'b0011,
    parameter logic [3:0] ADDR_A     = 4'b0000,
    parameter logic [3:0] ADDR_B     = 4'b0001
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] sin_in,
    input  logic [DATA_WIDTH-1:0] cos_in,
    output logic                  dac_sclk,
    output logic                  dac_cs_n,
    output logic                  dac_mosi,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun
);

    localparam int HW = $clog2(SCLK_HALF) + 1;
    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [CW-1:0]         cnt;
    logic                  tick;
    logic [2:0]            state;
    logic [HW-1:0]         hcnt;
    logic                  half_end;
    logic [4:0]            bcnt;
    logic                  chan;
    logic [23:0]           shreg;
    logic [DATA_WIDTH-1:0] hold_b;

    // Left-justify the sample into 16 bits and prepend command/address.
    function automatic logic [23:0] frame_word(input logic [3:0] addr,
                                               input logic [DATA_WIDTH-1:0] s);
        logic [15:0] d;
        d = 16'(s) << (16 - DATA_WIDTH);
`ifdef OFFSET_BINARY_EN
        d[15] = ~d[15];
`endif
        return {CMD_WRITE, addr, d};
    endfunction

    assign tick     = en && (cnt == CW'(SAMPLE_DIV - 1));
    assign half_end = (hcnt == HW'(SCLK_HALF - 1));
    assign dac_mosi = shreg[23];

    // Sample-rate divider: free-runs while enabled, parked at zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Sticky overrun: a tick that finds the serialiser busy; disabling clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (!en) begin
            overrun <= 1'b0;
        end else if (tick && state != S_IDLE) begin
            overrun <= 1'b1;
        end
    end

    // Frame sequencer: SETUP, 24 SCLK periods, HOLD, GAP, once per channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            hcnt       <= '0;
            bcnt       <= '0;
            chan       <= 1'b0;
            shreg      <= '0;
            hold_b     <= '0;
            dac_sclk   <= 1'b0;
            dac_cs_n   <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tick) begin
                        hold_b   <= cos_in;
                        shreg    <= frame_word(ADDR_A, sin_in);
                        chan     <= 1'b0;
                        hcnt     <= '0;
                        busy     <= 1'b1;
                        dac_cs_n <= 1'b0;
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (half_end) begin
                        hcnt     <= '0;
                        bcnt     <= '0;
                        dac_sclk <= 1'b1;
                        state    <= S_SHIFT;
                    end else begin
                        hcnt <= hcnt + HW'(1);
                    end
                end
                S_SHIFT: begin
                    if (!half_end) begin
                        hcnt <= hcnt + HW'(1);
                    end else begin
                        hcnt <= '0;
                        if (dac_sclk) begin
                            dac_sclk <= 1'b0;
                            shreg    <= {shreg[22:0], 1'b0};
                        end else if (bcnt == 5'd23) begin
                            state <= S_HOLD;
                        end else begin
                            bcnt     <= bcnt + 5'd1;
                            dac_sclk <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (half_end) begin
                        hcnt     <= '0;
                        dac_cs_n <= 1'b1;
                        shreg    <= '0;
                        state    <= S_GAP;
                    end else begin
                        hcnt <= hcnt + HW'(1);
                    end
                end
                S_GAP: begin
                    if (!half_end) begin
                        hcnt <= hcnt + HW'(1);
                    end else begin
                        hcnt <= '0;
                        if (!chan) begin
                            chan     <= 1'b1;
                            shreg    <= frame_word(ADDR_B, hold_b);
                            dac_cs_n <= 1'b0;
                            state    <= S_SETUP;
                        end else begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nco_dac_spi.sv
// tb_nco_dac_spi: scoreboard bench for nco_dac_spi, default build plus a
// fast-tick 12-bit build that provokes overruns.
module tb_nco_dac_spi;

    localparam int H    = 2;
    localparam int PAIR = 102 * H;
    localparam int DIV0 = 250;
    localparam int DIV1 = 150;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic [15:0] sin0  = 16'h1234;
    logic [15:0] cos0  = 16'hABCD;
    logic [11:0] sin1  = 12'hABC;
    logic [11:0] cos1  = 12'h123;

    logic sclk0, cs0, mosi0, busy0, done0, ovr0;
    logic sclk1, cs1, mosi1, busy1, done1, ovr1;

    always #5 clk = ~clk;

    nco_dac_spi #(.DATA_WIDTH(16), .SCLK_HALF(H), .SAMPLE_DIV(DIV0)) u_dac0 (
        .clk(clk), .rst_n(rst_n), .en(en), .sin_in(sin0), .cos_in(cos0),
        .dac_sclk(sclk0), .dac_cs_n(cs0), .dac_mosi(mosi0),
        .busy(busy0), .frame_done(done0), .overrun(ovr0));

    nco_dac_spi #(.DATA_WIDTH(12), .SCLK_HALF(H), .SAMPLE_DIV(DIV1)) u_dac1 (
        .clk(clk), .rst_n(rst_n), .en(en), .sin_in(sin1), .cos_in(cos1),
        .dac_sclk(sclk1), .dac_cs_n(cs1), .dac_mosi(mosi1),
        .busy(busy1), .frame_done(done1), .overrun(ovr1));

    logic [1:0] sclk_v, cs_v, mosi_v, busy_v, done_v, ovr_v;
    assign sclk_v = {sclk1, sclk0};
    assign cs_v   = {cs1, cs0};
    assign mosi_v = {mosi1, mosi0};
    assign busy_v = {busy1, busy0};
    assign done_v = {done1, done0};
    assign ovr_v  = {ovr1, ovr0};

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    typedef struct {
        int          id;
        logic [23:0] word;
        int          start;
    } exp_t;

    exp_t exp_q[$];

    int         cyc = 0;
    int         mcnt[2];
    int         mbusy[2];
    logic [1:0] mov   = '0;
    logic [1:0] mdone = '0;

    function automatic logic [23:0] word_of(input logic [3:0] addr,
                                            input logic [15:0] data);
`ifdef OFFSET_BINARY_EN
        data = data ^ 16'h8000;
`endif
        return {4'h3, addr, data};
    endfunction

    function automatic logic tick_of(input int i);
        return en && (mcnt[i] == ((i == 0) ? DIV0 : DIV1) - 1);
    endfunction

    task automatic push_pair(input int i, input int st);
        exp_t e;
        e.id    = i;
        e.start = st;
        e.word  = (i == 0) ? word_of(4'h0, sin0) : word_of(4'h0, {sin1, 4'h0});
        exp_q.push_back(e);
        e.start = st + PAIR / 2;
        e.word  = (i == 0) ? word_of(4'h1, cos0) : word_of(4'h1, {cos1, 4'h0});
        exp_q.push_back(e);
    endtask

    // Reference model: tick timing, pair occupancy, overrun, frame_done.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mcnt[i]  <= 0;
                mbusy[i] <= 0;
            end
            mov   <= '0;
            mdone <= '0;
            exp_q.delete();
        end else begin
            cyc <= cyc + 1;
            for (int i = 0; i < 2; i++) begin
                mdone[i] <= (mbusy[i] == 1);
                if (!en) mov[i] <= 1'b0;
                else if (tick_of(i) && mbusy[i] != 0) mov[i] <= 1'b1;
                mcnt[i] <= (!en || tick_of(i)) ? 0 : mcnt[i] + 1;
                if (tick_of(i) && mbusy[i] == 0) begin
                    mbusy[i] <= PAIR;
                    push_pair(i, cyc + 1);
                end else if (mbusy[i] != 0) begin
                    mbusy[i] <= mbusy[i] - 1;
                end
            end
        end
    end

    logic [1:0]  infr  = '0;
    logic [1:0]  pcs   = '1;
    logic [1:0]  psclk = '0;
    logic [23:0] sh[2];
    int          fcyc[2];
    int          edges[2];

    task automatic sb_pop(input int i, input logic [23:0] got,
                          input int st, input int ne);
        int idx;
        idx = -1;
        for (int k = 0; k < exp_q.size(); k++)
            if (idx < 0 && exp_q[k].id == i) idx = k;
        check($sformatf("dac%0d_frame_expected", i), 32'(idx >= 0), 1);
        if (idx >= 0) begin
            check($sformatf("dac%0d_word", i), 32'(got), 32'(exp_q[idx].word));
            check($sformatf("dac%0d_start", i), st, exp_q[idx].start);
            check($sformatf("dac%0d_sclk_edges", i), ne, 24);
            check($sformatf("dac%0d_cs_low_len", i), cyc - st, 50 * H);
            exp_q.delete(idx);
        end
    endtask

    // SPI monitor and per-cycle status comparison.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("dac%0d_busy", i), 32'(busy_v[i]), 32'(mbusy[i] != 0));
            check($sformatf("dac%0d_overrun", i), 32'(ovr_v[i]), 32'(mov[i]));
            check($sformatf("dac%0d_frame_done", i), 32'(done_v[i]), 32'(mdone[i]));
            if (!rst_n) begin
                infr[i] <= 1'b0;
            end else if (!cs_v[i] && pcs[i]) begin
                infr[i]  <= 1'b1;
                fcyc[i]  <= cyc;
                sh[i]    <= '0;
                edges[i] <= 0;
            end else if (infr[i] && sclk_v[i] && !psclk[i]) begin
                sh[i]    <= {sh[i][22:0], mosi_v[i]};
                edges[i] <= edges[i] + 1;
            end else if (infr[i] && cs_v[i] && !pcs[i]) begin
                sb_pop(i, sh[i], fcyc[i], edges[i]);
                infr[i] <= 1'b0;
            end
            psclk[i] <= sclk_v[i];
            pcs[i]   <= cs_v[i];
        end
    end

    task automatic check_idle(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s%0d_sclk", tag, i), 32'(sclk_v[i]), 0);
            check($sformatf("%s%0d_cs_n", tag, i), 32'(cs_v[i]), 1);
            check($sformatf("%s%0d_mosi", tag, i), 32'(mosi_v[i]), 0);
            check($sformatf("%s%0d_busy", tag, i), 32'(busy_v[i]), 0);
            check($sformatf("%s%0d_done", tag, i), 32'(done_v[i]), 0);
            check($sformatf("%s%0d_ovr", tag, i), 32'(ovr_v[i]), 0);
        end
    endtask

    initial begin
        int t;
        edges[0] = 0;
        edges[1] = 0;
        repeat (3) @(negedge clk);
        check_idle("reset");

        rst_n = 1'b1;
        en    = 1'b1;
        repeat (250) @(negedge clk);
        sin0 = 16'hFFFF;

        repeat (510) @(negedge clk);
        en = 1'b0;
        repeat (400) @(negedge clk);
        en = 1'b1;

        t = 0;
        while (edges[0] != 11 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("wait_bit10", 32'(edges[0] == 11), 1);
        #1 rst_n = 1'b0;
        #1 check_idle("abort");

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (480) @(negedge clk);
        en = 1'b0;
        repeat (300) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
